// File: rtl/id_issue_pkg.sv
// Shared RV32I decode definitions for the id_issue stage: opcodes, itype bit
// positions, ALU function codes and the packed issue bundle.
package id_issue_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One-hot itype bit positions: {R,I,S,B,U,J} occupies bits [5:0].
  localparam int ITYPE_R = 5;
  localparam int ITYPE_I = 4;
  localparam int ITYPE_S = 3;
  localparam int ITYPE_B = 2;
  localparam int ITYPE_U = 1;
  localparam int ITYPE_J = 0;

  // fun = {funct3, funct7}
  localparam logic [9:0] FUN_ADD = 10'h000;
  localparam logic [9:0] FUN_SUB = 10'h020;

  typedef struct packed {
    logic [9:0]      fun;
    logic [5:0]      itype;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/id_issue_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register M drives the output,
// skid register K catches the one beat that arrives while M is stalled.
module skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] m_data;
  logic [DW-1:0] k_data;
  logic          m_valid;
  logic          k_valid;
  logic          in_fire;
  logic          m_free;

  // in_ready depends only on K occupancy, so it never combinationally follows out_ready.
  assign in_ready  = ~k_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign in_fire   = in_valid & in_ready;
  assign m_free    = ~m_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      k_data  <= '0;
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      if (k_valid) begin
        m_data  <= k_data;
        m_valid <= 1'b1;
        k_valid <= 1'b0;
      end else begin
        m_valid <= in_fire;
        if (in_fire) m_data <= in_data;
      end
    end else if (in_fire) begin
      k_data  <= in_data;
      k_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/id_issue.sv
// RV32I decode/issue stage: decodes instruction + register operands into the
// ALU32 operand bundle and writeback tag, registered through a skid buffer.
module id_issue
  import id_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PCW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PCW-1:0]   in_pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_fun,
  output logic [5:0]       out_itype,
  output logic [WIDTH-1:0] out_in1,
  output logic [WIDTH-1:0] out_in2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_illegal
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_s;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] pc_x;
  logic             ok;
  logic             we;
  bundle_t          dec;
  bundle_t          held;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign pc_x  = WIDTH'(in_pc);

  always_comb begin
    dec    = '0;
    dec.rd = in_inst[11:7];
    ok     = (in_inst[1:0] == 2'b11);
    we     = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.itype[ITYPE_R] = 1'b1;
        dec.fun = {f3, f7};
        dec.in1 = rs1_data;
        dec.in2 = rs2_data;
        if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))))) ok = 1'b0;
      end
      OPC_OP_IMM: begin
        // funct7 is forced to 0 so addi never turns into a subtract; srai is
        // recognised by the ALU from in2[11:5].
        dec.itype[ITYPE_I] = 1'b1;
        dec.fun = {f3, 7'h00};
        dec.in1 = rs1_data;
        dec.in2 = imm_i;
        if ((f3 == 3'd1) && (f7 != 7'h00)) ok = 1'b0;
        if ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20)) ok = 1'b0;
      end
      OPC_LOAD: begin
        dec.itype[ITYPE_I] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in1 = rs1_data;
        dec.in2 = imm_i;
      end
      OPC_JALR: begin
        // ALU computes the link value; the target is formed elsewhere.
        dec.itype[ITYPE_I] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in1 = pc_x;
        dec.in2 = WIDTH'(4);
      end
      OPC_STORE: begin
        dec.itype[ITYPE_S] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in1 = rs1_data;
        dec.in2 = imm_s;
        we = 1'b0;
      end
      OPC_BRANCH: begin
        dec.itype[ITYPE_B] = 1'b1;
        dec.fun = FUN_SUB;
        dec.in1 = rs1_data;
        dec.in2 = rs2_data;
        we = 1'b0;
      end
      OPC_LUI: begin
        dec.itype[ITYPE_U] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.itype[ITYPE_U] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in1 = pc_x;
        dec.in2 = imm_u;
      end
      OPC_JAL: begin
        dec.itype[ITYPE_J] = 1'b1;
        dec.fun = FUN_ADD;
        dec.in1 = pc_x;
        dec.in2 = WIDTH'(4);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec.fun   = '0;
      dec.itype = '0;
      dec.in1   = '0;
      dec.in2   = '0;
    end
    dec.illegal = ~ok;
    dec.rd_we   = we & ok & (dec.rd != 5'd0);
  end

  // Handshake: a beat moves on in_valid & in_ready (input) and on
  // out_valid & out_ready (output); valid never waits on ready, and a presented
  // output holds its value until accepted or flushed.
  skid_buf #(.DW(BUNDLE_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign out_fun     = held.fun;
  assign out_itype   = held.itype;
  assign out_in1     = held.in1;
  assign out_in2     = held.in2;
  assign out_rd      = held.rd;
  assign out_rd_we   = held.rd_we;
  assign out_illegal = held.illegal;

endmodule
